multicycle_chunk_adder: RTL and testbench



---
 rtl/adder_pkg.sv | 17 +
 rtl/multicycle_chunk_adder_if.sv | 27 ++
 rtl/chunk_ripple_adder.sv | 29 ++
 rtl/multicycle_chunk_adder.sv | 116 +++++++++++
 tb/tb_multicycle_chunk_adder.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/adder_pkg.sv
// Shared types and helpers for the chunked sequential adder.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic ADD = 1'b0;
  localparam logic SUB = 1'b1;

  function automatic int nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

endpackage

// File: rtl/multicycle_chunk_adder_if.sv
// Start/done request bus of the chunked adder: operands in, result and flags out.
interface multicycle_chunk_adder_if #(
  parameter int WIDTH = 16
);

  logic             start;
  logic             sub;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] S;
  logic             cout;
  logic             ovf;

  modport master (
    output start, sub, A, B, cin,
    input  busy, done, S, cout, ovf
  );

  modport slave (
    input  start, sub, A, B, cin,
    output busy, done, S, cout, ovf
  );

endinterface

// File: rtl/chunk_ripple_adder.sv
// Combinational CHUNK-bit ripple of full adders; also exposes the carry into
// the top bit so the caller can derive signed overflow.
module chunk_ripple_adder #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             c_msb
);

  logic [CHUNK:0] c;

  always_comb begin
    s    = '0;
    c    = '0;
    c[0] = ci;
    for (int i = 0; i < CHUNK; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign co    = c[CHUNK];
  assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/multicycle_chunk_adder.sv
// Sequential WIDTH-bit add/subtract, one CHUNK-bit slice per clock through a
// single shared ripple slice; result and flags publish with a one-cycle done.
module multicycle_chunk_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input logic                     Clk,
  input logic                     Reset,
  multicycle_chunk_adder_if.slave bus
);

  localparam int NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NCHUNK - 1);

  if ((CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_bad_param
    $error("multicycle_chunk_adder: WIDTH (%0d) must be a multiple of CHUNK (%0d)", WIDTH, CHUNK);
  end

  state_t           state_q;
  logic [KW-1:0]    k_q;
  logic [WIDTH-1:0] opa_q;
  logic [WIDTH-1:0] opb_q;
  logic [WIDTH-1:0] work_q;
  logic             carry_q;
  logic [WIDTH-1:0] s_q;
  logic             cout_q;
  logic             ovf_q;
  logic             busy_q;
  logic             done_q;

  logic [31:0]      base;
  logic [CHUNK-1:0] slice_a;
  logic [CHUNK-1:0] slice_b;
  logic [CHUNK-1:0] slice_s;
  logic             slice_co;
  logic             slice_cmsb;
  logic [WIDTH-1:0] work_d;

  // Work register with the current slice merged in, so the final edge can
  // publish the complete sum without an extra cycle.
  always_comb begin
    base    = 32'(k_q) * 32'(CHUNK);
    slice_a = opa_q[base +: CHUNK];
    slice_b = opb_q[base +: CHUNK];
    work_d  = work_q;
    work_d[base +: CHUNK] = slice_s;
  end

  chunk_ripple_adder #(
    .CHUNK(CHUNK)
  ) u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .ci   (carry_q),
    .s    (slice_s),
    .co   (slice_co),
    .c_msb(slice_cmsb)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      k_q     <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      work_q  <= '0;
      carry_q <= 1'b0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            opa_q   <= bus.A;
            opb_q   <= (bus.sub == SUB) ? ~bus.B : bus.B;
            carry_q <= (bus.sub == ADD) ? bus.cin : 1'b1;
            k_q     <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          work_q  <= work_d;
          carry_q <= slice_co;
          if (k_q == K_LAST) begin
            s_q     <= work_d;
            cout_q  <= slice_co;
            ovf_q   <= slice_cmsb ^ slice_co;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            k_q <= k_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.S    = s_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_multicycle_chunk_adder.sv
// Scoreboard bench: stimulus queues expected results, per-DUT monitors check on done.
module tb_multicycle_chunk_adder;
  import adder_pkg::*;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] s;
    logic        cout;
    logic        ovf;
    int          cyc;
    int          id;
  } exp_t;

  exp_t q16[$];
  exp_t q32[$];
  exp_t q8[$];

  int done16 = 0;
  int busy16 = 0;

  multicycle_chunk_adder_if #(.WIDTH(16)) if16 ();
  multicycle_chunk_adder_if #(.WIDTH(32)) if32 ();
  multicycle_chunk_adder_if #(.WIDTH(8))  if8 ();

  multicycle_chunk_adder #(.WIDTH(16), .CHUNK(4)) u16 (.Clk(Clk), .Reset(Reset), .bus(if16));
  multicycle_chunk_adder #(.WIDTH(32), .CHUNK(8)) u32 (.Clk(Clk), .Reset(Reset), .bus(if32));
  multicycle_chunk_adder #(.WIDTH(8),  .CHUNK(8)) u8  (.Clk(Clk), .Reset(Reset), .bus(if8));

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic compare_result(input string tag, input exp_t e, input logic [31:0] s,
                                input logic c, input logic o, input int now);
    check($sformatf("%s#%0d_S", tag, e.id), s, e.s);
    check($sformatf("%s#%0d_cout", tag, e.id), 32'(c), 32'(e.cout));
    check($sformatf("%s#%0d_ovf", tag, e.id), 32'(o), 32'(e.ovf));
    check($sformatf("%s#%0d_done_cycle", tag, e.id), 32'(now), 32'(e.cyc));
  endtask

  task automatic unexpected(input string tag, input int now);
    tests++;
    fails++;
    $display("FAIL %s_unexpected_done: got done at cycle %0d expected no done", tag, now);
  endtask

  always @(negedge Clk) begin
    if (if16.busy) busy16++;
    if (if16.done) begin
      done16++;
      if (q16.size() == 0) unexpected("w16", cyc);
      else compare_result("w16", q16.pop_front(), 32'(if16.S), if16.cout, if16.ovf, cyc);
    end
    if (if32.done) begin
      if (q32.size() == 0) unexpected("w32", cyc);
      else compare_result("w32", q32.pop_front(), if32.S, if32.cout, if32.ovf, cyc);
    end
    if (if8.done) begin
      if (q8.size() == 0) unexpected("w8", cyc);
      else compare_result("w8", q8.pop_front(), 32'(if8.S), if8.cout, if8.ovf, cyc);
    end
  end

  // One-cycle start pulse; done is due NCHUNK edges after the sampling edge.
  task automatic issue(input int w, input int id, input logic sb, input logic [31:0] a,
                       input logic [31:0] b, input logic ci, input logic [31:0] es,
                       input logic ec, input logic eo);
    exp_t e;
    @(negedge Clk);
    e.s = es; e.cout = ec; e.ovf = eo; e.id = id;
    case (w)
      32: begin
        if32.start = 1'b1; if32.sub = sb; if32.A = a; if32.B = b; if32.cin = ci;
        e.cyc = cyc + 1 + 4; q32.push_back(e);
      end
      8: begin
        if8.start = 1'b1; if8.sub = sb; if8.A = a[7:0]; if8.B = b[7:0]; if8.cin = ci;
        e.cyc = cyc + 1 + 1; q8.push_back(e);
      end
      default: begin
        if16.start = 1'b1; if16.sub = sb; if16.A = a[15:0]; if16.B = b[15:0]; if16.cin = ci;
        e.cyc = cyc + 1 + 4; q16.push_back(e);
      end
    endcase
    @(negedge Clk);
    if16.start = 1'b0; if32.start = 1'b0; if8.start = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && (q16.size() + q32.size() + q8.size()) > 0; i++) @(negedge Clk);
    if ((q16.size() + q32.size() + q8.size()) > 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: got %0d results outstanding expected 0",
               q16.size() + q32.size() + q8.size());
      q16.delete(); q32.delete(); q8.delete();
    end
  endtask

  initial begin
    int b0, d0, c0;
    exp_t e;
    Reset = 1'b1;
    if16.start = 0; if16.sub = 0; if16.A = '0; if16.B = '0; if16.cin = 0;
    if32.start = 0; if32.sub = 0; if32.A = '0; if32.B = '0; if32.cin = 0;
    if8.start  = 0; if8.sub  = 0; if8.A  = '0; if8.B  = '0; if8.cin  = 0;
    repeat (3) @(negedge Clk);
    check("reset_S", 32'(if16.S), 32'h0);
    check("reset_cout", 32'(if16.cout), 32'h0);
    check("reset_ovf", 32'(if16.ovf), 32'h0);
    check("reset_busy", 32'(if16.busy), 32'h0);
    check("reset_done", 32'(if16.done), 32'h0);
    Reset = 1'b0;

    b0 = busy16;
    issue(16, 1, ADD, 32'h0001, 32'h0001, 1'b0, 32'h0002, 1'b0, 1'b0);
    drain();
    check("busy_cycles", 32'(busy16 - b0), 32'd4);
    repeat (3) @(negedge Clk);
    check("hold_S_idle", 32'(if16.S), 32'h0002);

    issue(16, 2, ADD, 32'hFFFF, 32'h0001, 1'b0, 32'h0000, 1'b1, 1'b0);
    @(negedge Clk);
    check("hold_S_run", 32'(if16.S), 32'h0002);
    drain();
    issue(16, 3, ADD, 32'hFFFF, 32'h0000, 1'b1, 32'h0000, 1'b1, 1'b0);
    drain();
    issue(16, 4, ADD, 32'h7FFF, 32'h0001, 1'b0, 32'h8000, 1'b0, 1'b1);
    drain();
    issue(16, 5, SUB, 32'h0005, 32'h0007, 1'b1, 32'hFFFE, 1'b0, 1'b0);
    drain();
    issue(16, 6, SUB, 32'h8000, 32'h0001, 1'b0, 32'h7FFF, 1'b1, 1'b1);
    drain();

    // Abort on the second RUN cycle: no done, outputs cleared.
    d0 = done16;
    @(negedge Clk);
    if16.start = 1'b1; if16.sub = ADD; if16.A = 16'h0009; if16.B = 16'h0009; if16.cin = 1'b0;
    @(negedge Clk);
    if16.start = 1'b0;
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    check("midrun_reset_S", 32'(if16.S), 32'h0);
    check("midrun_reset_cout", 32'(if16.cout), 32'h0);
    check("midrun_reset_ovf", 32'(if16.ovf), 32'h0);
    check("midrun_reset_busy", 32'(if16.busy), 32'h0);
    Reset = 1'b0;
    repeat (6) @(negedge Clk);
    check("midrun_reset_no_done", 32'(done16 - d0), 32'd0);
    issue(16, 7, ADD, 32'h0003, 32'h0004, 1'b0, 32'h0007, 1'b0, 1'b0);
    drain();

    d0 = done16;
    issue(16, 8, ADD, 32'h0001, 32'h0002, 1'b0, 32'h0003, 1'b0, 1'b0);
    @(negedge Clk);
    if16.start = 1'b1; if16.A = 16'hFFFF; if16.B = 16'hFFFF;
    @(negedge Clk);
    if16.start = 1'b0;
    drain();
    repeat (6) @(negedge Clk);
    check("start_in_run_ignored", 32'(done16 - d0), 32'd1);

    // start held high through DONE: second op follows with no idle cycle.
    @(negedge Clk);
    c0 = cyc;
    if16.start = 1'b1; if16.sub = ADD; if16.A = 16'h1111; if16.B = 16'h2222; if16.cin = 1'b0;
    e.s = 32'h3333; e.cout = 1'b0; e.ovf = 1'b0; e.cyc = c0 + 5;  e.id = 9;  q16.push_back(e);
    e.s = 32'h0030; e.cout = 1'b0; e.ovf = 1'b0; e.cyc = c0 + 10; e.id = 10; q16.push_back(e);
    @(negedge Clk);
    if16.A = 16'h0010; if16.B = 16'h0020;
    for (int i = 0; i < 20 && cyc < c0 + 6; i++) @(negedge Clk);
    if16.start = 1'b0;
    drain();

    issue(32, 11, ADD, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0, 1'b1, 1'b0);
    drain();
    issue(32, 12, SUB, 32'h0000_0005, 32'h0000_0007, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0);
    drain();
    issue(8, 13, ADD, 32'h7F, 32'h01, 1'b0, 32'h80, 1'b0, 1'b1);
    drain();
    issue(8, 14, SUB, 32'h80, 32'h01, 1'b0, 32'h7F, 1'b1, 1'b1);
    drain();

    repeat (4) @(negedge Clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    fails++;
    $display("FAIL watchdog: got no completion by %0t expected completion", $time);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog expired");
  end

endmodule
